data_sram_resp: RTL and testbench
=================================

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: word-index bits, giving 2^ADDR_W x 32-bit words of storage.
REQ-002 SHALL have parameter LATENCY, default 2: minimum cycles from request acceptance to data_ok; legal range 1..7.
REQ-003 SHALL have parameter DEPTH, default 2: maximum outstanding accepted-but-unanswered requests; legal range 1..4.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port req, input, 1: requester presents a transaction.
REQ-007 SHALL have port wr, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port size, input, 2: 0 = byte, 1 = half, 2 = word; informational only, wstrb is authoritative.
REQ-009 SHALL have port addr, input, 32: byte address; word index = addr[ADDR_W+1:2]; higher bits ignored (aliasing).
REQ-010 SHALL have port wstrb, input, 4: per-byte write enables, bit i selects wdata[8i+7:8i].
REQ-011 SHALL have port wdata, input, 32: write data, byte lanes aligned to the word.
REQ-012 SHALL have port addr_ok, output, 1: request accepted this cycle when req & addr_ok.
REQ-013 SHALL have port data_ok, output, 1: one-cycle pulse per accepted request, in acceptance order.
REQ-014 SHALL have port rdata, output, 32: full-word read data, valid only while data_ok is high for a read.

Function
REQ-015 SHALL hold accepted requests in an in-order queue of DEPTH entries; each entry stores {wr, word index, wstrb, wdata, countdown}.
REQ-016 SHALL drive addr_ok = (occupancy < DEPTH), registered-state-only; no same-cycle bypass when full, even if head retires that cycle.
REQ-017 SHALL load an entry's countdown with LATENCY-1 on acceptance and decrement every cycle, saturating at 0.
REQ-018 SHALL assert data_ok in a cycle iff queue is non-empty and head countdown == 0; the head retires at that clock edge.
REQ-019 SHALL thus give isolated-request latency of exactly LATENCY cycles (accept in cycle t, data_ok in t+LATENCY) and, back-to-back, data_ok no earlier than previous data_ok + 1.
REQ-020 SHALL, for a read at head, drive rdata combinationally from storage[head index] during the data_ok cycle; rdata = 0 when data_ok is low.
REQ-021 SHALL, for a write at head, update only strobed bytes of storage[head index] at the clock edge ending the data_ok cycle; wstrb = 0 still produces data_ok with no storage change.
REQ-022 SHALL order effects by retirement: a read retiring after a write to the same word returns the written bytes; a read accepted before a younger write returns old data.
REQ-023 SHALL support simultaneous acceptance and retirement in one cycle; occupancy unchanged, both entries handled correctly.
REQ-024 SHALL ignore req while addr_ok is low; wr/addr/wstrb/wdata sampled only at acceptance.
REQ-025 SHALL never emit data_ok without a matching accepted request and never drop an accepted request.

Reset
REQ-026 SHALL, on resetn low, immediately clear queue occupancy, pointers and countdowns; addr_ok = 1 (DEPTH >= 1), data_ok = 0, rdata = 0.
REQ-027 SHALL discard in-flight requests on reset mid-operation; no data_ok for them after release, pending writes not committed.
REQ-028 SHALL not initialise storage contents; contents persist across reset.

Verification
REQ-029 SHALL pass: write addr 0x10, wstrb 4'hF, wdata 0xDEADBEEF accepted cycle 0 -> data_ok cycle 2; read 0x10 accepted cycle 3 -> data_ok cycle 5 with rdata 0xDEADBEEF.
REQ-030 SHALL pass: after word 0x10 = 0xDEADBEEF, write wstrb 4'b0010 wdata 0x0000AA00 then read 0x10 back-to-back -> rdata 0xDEADAAEF, data_ok in consecutive cycles.
REQ-031 SHALL pass: req held high with DEPTH = 2, LATENCY = 2 -> addr_ok low exactly when 2 outstanding, data_ok count equals accepted count, order preserved.
REQ-032 SHALL pass: read 0x10 then write 0x10 = 0x12345678 accepted back-to-back -> read returns old 0xDEADBEEF; subsequent read returns 0x12345678.
REQ-033 SHALL pass: resetn pulsed low one cycle after accepting a write of 0x55555555 to 0x20 over old 0x11111111 -> no data_ok follows, addr_ok = 1, later read of 0x20 returns 0x11111111.
REQ-034 SHALL pass: addr 0x1010 with ADDR_W = 10 -> aliases to word 4 (same as addr 0x10); wstrb 0 write -> data_ok, storage unchanged.

Source files
------------

// File: rtl/data_sram_resp.sv
// Single-port 32-bit SRAM with a req/addr_ok, data_ok handshake: accepted requests
// wait in an in-order queue and take effect on storage only when they retire.
module data_sram_resp #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [2:0] CD_INIT = 3'(LATENCY - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] idx;
        logic [3:0]        wstrb;
        logic [31:0]       wdata;
        logic [2:0]        cd;
    } entry_t;

    entry_t           q [DEPTH];
    entry_t           head_e;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [31:0]      mem [1 << ADDR_W];
    logic             accept;
    logic             retire;
    logic             unused_bits;

    // size is informational and the upper address bits alias, so none of them feed logic
    assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : PTR_W'(p + 1'b1);
    endfunction

    assign head_e  = q[head];
    assign addr_ok = (count < CNT_FULL);
    assign accept  = req && addr_ok;
    assign retire  = (count != '0) && (head_e.cd == 3'd0);
    assign data_ok = retire;

    always_comb begin
        rdata = 32'h0;
        if (retire && !head_e.wr) begin
            rdata = mem[head_e.idx];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q[i].cd != 3'd0) begin
                    q[i].cd <= q[i].cd - 3'd1;
                end
            end
            if (accept) begin
                q[tail] <= '{wr: wr, idx: addr[ADDR_W+1:2], wstrb: wstrb,
                             wdata: wdata, cd: CD_INIT};
                tail    <= ptr_inc(tail);
            end
            if (retire) begin
                head <= ptr_inc(head);
            end
            if (accept && !retire) begin
                count <= count + 1'b1;
            end else if (!accept && retire) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage is deliberately left unreset so its contents survive resetn
    always_ff @(posedge clk) begin
        if (retire && head_e.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (head_e.wstrb[b]) begin
                    mem[head_e.idx][8*b +: 8] <= head_e.wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: requests push expectations, a monitor pops
// and compares on every data_ok, also tracking addr_ok against the outstanding count.
module tb_data_sram_resp;

    localparam int ADDR_W  = 10;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    typedef struct {
        logic        is_write;
        logic [31:0] exp;
        int          c0;
        bit          exact;
    } sb_t;

    sb_t sb[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  cyc         = 0;

    data_sram_resp #(.ADDR_W(ADDR_W), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .addr    (addr),
        .wstrb   (wstrb),
        .wdata   (wdata),
        .addr_ok (addr_ok),
        .data_ok (data_ok),
        .rdata   (rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: addr_ok must reflect outstanding entries; each data_ok retires the oldest one
    always @(posedge clk) begin
        #1;
        if (resetn) begin
            check_output("addr_ok", 32'(addr_ok), 32'(sb.size() < DEPTH));
            if (data_ok) begin
                if (sb.size() == 0) begin
                    check_output("data_ok_spurious", 32'(data_ok), 32'd0);
                end else begin
                    automatic sb_t e = sb.pop_front();
                    automatic int lat = cyc - e.c0;
                    if (!e.is_write) check_output("rdata", rdata, e.exp);
                    if (e.exact) check_output("latency", 32'(lat), 32'(LATENCY));
                    else         check_output("latency_min", 32'(lat >= LATENCY), 32'd1);
                end
            end else begin
                check_output("rdata_idle", rdata, 32'h0);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic apply_stimulus(input logic w, input logic [31:0] a, input logic [3:0] s,
                                  input logic [31:0] d, input logic [31:0] exp, input bit exact);
        int waited = 0;
        req   = 1'b1;
        wr    = w;
        addr  = a;
        wstrb = s;
        wdata = d;
        size  = 2'd2;
        while (!addr_ok && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!addr_ok) begin
            check_output("accept_timeout", 32'(addr_ok), 32'd1);
            req = 1'b0;
            return;
        end
        sb.push_back('{is_write: w, exp: exp, c0: cyc, exact: exact});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int waited = 0;
        req = 1'b0;
        while (sb.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_output("drain", 32'(sb.size()), 32'd0);
        idle(2);
    endtask

    initial begin
        resetn = 1'b0;
        req    = 1'b0;
        wr     = 1'b0;
        size   = 2'd0;
        addr   = '0;
        wstrb  = '0;
        wdata  = '0;
        repeat (2) @(negedge clk);
        check_output("reset_addr_ok", 32'(addr_ok), 32'd1);
        check_output("reset_data_ok", 32'(data_ok), 32'd0);
        check_output("reset_rdata", rdata, 32'h0);
        resetn = 1'b1;
        idle(2);

        // Isolated write then read
        apply_stimulus(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b1);
        idle(3);
        apply_stimulus(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1);
        drain();

        // Single-byte merge, back-to-back write then read
        apply_stimulus(1'b1, 32'h10, 4'b0010, 32'h0000AA00, 32'h0, 1'b1);
        apply_stimulus(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADAAEF, 1'b1);
        drain();

        // Older read sees old data, younger read sees the new write
        apply_stimulus(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b1);
        drain();
        apply_stimulus(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);
        apply_stimulus(1'b1, 32'h10, 4'hF, 32'h12345678, 32'h0, 1'b0);
        apply_stimulus(1'b0, 32'h10, 4'h0, 32'h0, 32'h12345678, 1'b0);
        drain();

        // req held high: queue fills, addr_ok throttles, order preserved
        apply_stimulus(1'b1, 32'h40, 4'hF, 32'hA0A0A0A0, 32'h0, 1'b0);
        apply_stimulus(1'b1, 32'h44, 4'hF, 32'hB1B1B1B1, 32'h0, 1'b0);
        apply_stimulus(1'b1, 32'h48, 4'hF, 32'hC2C2C2C2, 32'h0, 1'b0);
        apply_stimulus(1'b0, 32'h40, 4'h0, 32'h0, 32'hA0A0A0A0, 1'b0);
        apply_stimulus(1'b0, 32'h44, 4'h0, 32'h0, 32'hB1B1B1B1, 1'b0);
        apply_stimulus(1'b0, 32'h48, 4'h0, 32'h0, 32'hC2C2C2C2, 1'b0);
        drain();

        // Address aliasing and zero-strobe write
        apply_stimulus(1'b1, 32'h1010, 4'hF, 32'hCAFEF00D, 32'h0, 1'b1);
        drain();
        apply_stimulus(1'b0, 32'h10, 4'h0, 32'h0, 32'hCAFEF00D, 1'b1);
        drain();
        apply_stimulus(1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b1);
        drain();
        apply_stimulus(1'b0, 32'h1010, 4'h0, 32'h0, 32'hCAFEF00D, 1'b1);
        drain();

        // Reset mid-flight discards a pending write
        apply_stimulus(1'b1, 32'h20, 4'hF, 32'h11111111, 32'h0, 1'b1);
        drain();
        apply_stimulus(1'b1, 32'h20, 4'hF, 32'h55555555, 32'h0, 1'b1);
        req    = 1'b0;
        resetn = 1'b0;
        sb.delete();
        #1;
        check_output("midreset_addr_ok", 32'(addr_ok), 32'd1);
        check_output("midreset_data_ok", 32'(data_ok), 32'd0);
        check_output("midreset_rdata", rdata, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        idle(5);
        apply_stimulus(1'b0, 32'h20, 4'h0, 32'h0, 32'h11111111, 1'b1);
        drain();

        check_output("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
